// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI/host RAM arbiter.
package spi_arb_pkg;

    typedef enum logic [1:0] {
        ARB = 2'd0,
        ACC = 2'd1,
        RD  = 2'd2
    } state_e;

    localparam logic [1:0] OP_WADDR = 2'b00;
    localparam logic [1:0] OP_WDATA = 2'b01;
    localparam logic [1:0] OP_RADDR = 2'b10;
    localparam logic [1:0] OP_RDATA = 2'b11;

    typedef enum logic {
        WIN_SPI  = 1'b0,
        WIN_HOST = 1'b1
    } win_e;

endpackage

// File: rtl/spi_arb_rr.sv
// Two-way winner select between SPI and host. Define SPI_ARB_RR_EN for round-robin
// on ties; otherwise SPI has fixed priority.
module spi_arb_rr
    import spi_arb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic arb_en,
    input  logic spi_req,
    input  logic host_req,
    output logic win_spi
);

`ifdef SPI_ARB_RR_EN
    win_e last_q, last_d;

    // SPI takes a tie unless it also took the previous tie.
    assign win_spi = spi_req & (~host_req | (last_q == WIN_HOST));

    always_comb begin
        last_d = last_q;
        if (arb_en && spi_req && host_req) begin
            last_d = win_spi ? WIN_SPI : WIN_HOST;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= WIN_HOST;
        end else begin
            last_q <= last_d;
        end
    end
`else
    logic unused_rr;
    assign unused_rr = clk ^ rst ^ arb_en ^ host_req;
    assign win_spi   = spi_req;
`endif

endmodule

// File: rtl/spi_ram_arbiter.sv
// Decodes SPI frames into address loads and RAM commands, and arbitrates the single RAM
// port between SPI and a local host. Tie policy selected by SPI_ARB_RR_EN.
module spi_ram_arbiter
    import spi_arb_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W+1:0] rx_data,
    input  logic              rx_valid,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_rvalid,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              spi_ovf
);

    state_e            state_q, state_d;
    win_e              win_q, win_d;
    logic              pend_v_q, pend_v_d, pend_we_q, pend_we_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic [DATA_W-1:0] pend_data_q, pend_data_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
    logic              spi_ovf_q, spi_ovf_d;
    logic              ram_en_q, ram_en_d, ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic              host_gnt_q, host_gnt_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d, host_rdata_q, host_rdata_d;
    logic              tx_valid_q, tx_valid_d, host_rvalid_q, host_rvalid_d;

    logic              win_spi, spi_take;
    logic [1:0]        op;
    logic [DATA_W-1:0] payload;

    assign op      = rx_data[DATA_W+1:DATA_W];
    assign payload = rx_data[DATA_W-1:0];

    spi_arb_rr u_rr (
        .clk      (clk),
        .rst      (rst),
        .arb_en   (state_q == ARB),
        .spi_req  (pend_v_q),
        .host_req (host_req),
        .win_spi  (win_spi)
    );

    always_comb begin
        state_d       = state_q;
        win_d         = win_q;
        pend_v_d      = pend_v_q;
        pend_we_d     = pend_we_q;
        pend_addr_d   = pend_addr_q;
        pend_data_d   = pend_data_q;
        wr_addr_d     = wr_addr_q;
        rd_addr_d     = rd_addr_q;
        spi_ovf_d     = spi_ovf_q;
        ram_en_d      = 1'b0;
        ram_we_d      = 1'b0;
        ram_addr_d    = ram_addr_q;
        ram_wdata_d   = ram_wdata_q;
        host_gnt_d    = 1'b0;
        tx_data_d     = tx_data_q;
        tx_valid_d    = 1'b0;
        host_rdata_d  = host_rdata_q;
        host_rvalid_d = 1'b0;
        spi_take      = 1'b0;

        unique case (state_q)
            ARB: begin
                if (pend_v_q || host_req) begin
                    state_d  = ACC;
                    ram_en_d = 1'b1;
                    if (win_spi) begin
                        spi_take    = 1'b1;
                        win_d       = WIN_SPI;
                        ram_we_d    = pend_we_q;
                        ram_addr_d  = pend_addr_q;
                        ram_wdata_d = pend_data_q;
                    end else begin
                        win_d       = WIN_HOST;
                        host_gnt_d  = 1'b1;
                        ram_we_d    = host_we;
                        ram_addr_d  = host_addr;
                        ram_wdata_d = host_wdata;
                    end
                end
            end
            ACC: state_d = ram_we_q ? ARB : RD;
            RD: begin
                state_d = ARB;
                if (win_q == WIN_SPI) begin
                    tx_data_d  = ram_rdata;
                    tx_valid_d = 1'b1;
                end else begin
                    host_rdata_d  = ram_rdata;
                    host_rvalid_d = 1'b1;
                end
            end
            default: state_d = ARB;
        endcase

        if (spi_take) begin
            pend_v_d = 1'b0;
        end

        // Address snapshot uses the register value before any same-cycle load.
        if (rx_valid) begin
            if (op == OP_WADDR) begin
                wr_addr_d = payload[ADDR_W-1:0];
            end else if (op == OP_RADDR) begin
                rd_addr_d = payload[ADDR_W-1:0];
            end else if (!pend_v_q || spi_take) begin
                pend_v_d    = 1'b1;
                pend_we_d   = (op == OP_WDATA);
                pend_addr_d = (op == OP_WDATA) ? wr_addr_q : rd_addr_q;
                pend_data_d = payload;
            end else begin
                spi_ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ARB;
            win_q         <= WIN_SPI;
            pend_v_q      <= 1'b0;
            pend_we_q     <= 1'b0;
            pend_addr_q   <= '0;
            pend_data_q   <= '0;
            wr_addr_q     <= '0;
            rd_addr_q     <= '0;
            spi_ovf_q     <= 1'b0;
            ram_en_q      <= 1'b0;
            ram_we_q      <= 1'b0;
            ram_addr_q    <= '0;
            ram_wdata_q   <= '0;
            host_gnt_q    <= 1'b0;
            tx_data_q     <= '0;
            tx_valid_q    <= 1'b0;
            host_rdata_q  <= '0;
            host_rvalid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            win_q         <= win_d;
            pend_v_q      <= pend_v_d;
            pend_we_q     <= pend_we_d;
            pend_addr_q   <= pend_addr_d;
            pend_data_q   <= pend_data_d;
            wr_addr_q     <= wr_addr_d;
            rd_addr_q     <= rd_addr_d;
            spi_ovf_q     <= spi_ovf_d;
            ram_en_q      <= ram_en_d;
            ram_we_q      <= ram_we_d;
            ram_addr_q    <= ram_addr_d;
            ram_wdata_q   <= ram_wdata_d;
            host_gnt_q    <= host_gnt_d;
            tx_data_q     <= tx_data_d;
            tx_valid_q    <= tx_valid_d;
            host_rdata_q  <= host_rdata_d;
            host_rvalid_q <= host_rvalid_d;
        end
    end

    assign tx_data     = tx_data_q;
    assign tx_valid    = tx_valid_q;
    assign host_gnt    = host_gnt_q;
    assign host_rdata  = host_rdata_q;
    assign host_rvalid = host_rvalid_q;
    assign ram_en      = ram_en_q;
    assign ram_we      = ram_we_q;
    assign ram_addr    = ram_addr_q;
    assign ram_wdata   = ram_wdata_q;
    assign spi_ovf     = spi_ovf_q;

endmodule

// File: doc/spi_ram_arbiter.md
# spi_ram_arbiter

Sequencer and arbiter between the SPI slave command stream and the single-port RAM, with a second local host port sharing the same RAM. It decodes 10-bit SPI frames (`rx_data`/`rx_valid`) into address-register loads and RAM read/write accesses. It arbitrates SPI against host requests for the one RAM port and returns SPI read data on `tx_data`/`tx_valid`. It sits between the SPI slave and the RAM instance at the top level.

## Interface
- `DATA_W`, default 8: RAM word width; SPI frame width is `DATA_W+2`.
- `ADDR_W`, default 8: RAM address width; must satisfy `ADDR_W <= DATA_W`.
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  asynchronous reset, active-high.
- `rx_data`  in  DATA_W+2  SPI frame: [DATA_W+1:DATA_W] opcode, [DATA_W-1:0] payload.
- `rx_valid`  in  1  one-cycle pulse qualifying `rx_data`.
- `tx_data`  out  DATA_W  SPI read data.
- `tx_valid`  out  1  one-cycle pulse qualifying `tx_data`.
- `host_req`  in  1  host access request (level).
- `host_we`  in  1  1 = write, 0 = read.
- `host_addr`  in  ADDR_W  host address.
- `host_wdata`  in  DATA_W  host write data.
- `host_gnt`  out  1  one-cycle pulse: host access issued to RAM.
- `host_rdata`  out  DATA_W  host read data.
- `host_rvalid`  out  1  one-cycle pulse qualifying `host_rdata`.
- `ram_en`, `ram_we`  out  1 each  RAM enable and write strobe.
- `ram_addr`  out  ADDR_W  RAM address.
- `ram_wdata`  out  DATA_W  RAM write data.
- `ram_rdata`  in  DATA_W  RAM read data, valid the cycle after `ram_en && !ram_we`.
- `spi_ovf`  out  1  sticky flag: an SPI RAM command was dropped.

## Operation
- Opcodes:
  - `00`: `wr_addr <= payload[ADDR_W-1:0]`.
  - `10`: `rd_addr <= payload[ADDR_W-1:0]`.
  - Address loads act immediately, take no RAM cycle and are always accepted.
  - `01`: RAM write of `payload` at `wr_addr`.
  - `11`: RAM read at `rd_addr`; the payload is ignored.
- RAM commands are captured in a one-entry SPI pending register holding op, address (snapshot at capture) and data. A later address load does not alter the pending entry.
- A RAM command arriving while the pending entry is full and not being consumed that cycle is dropped and sets `spi_ovf`. `spi_ovf` is cleared only by `rst`.
- Host contract: `host_req`/`host_we`/`host_addr`/`host_wdata` stay stable from assertion until `host_gnt`.
- FSM states:
  - `ARB`:
    - no request → stay in `ARB`.
    - request(s) pending → pick a winner, go to `ACC`.
  - `ACC`:
    - drive `ram_en=1` and the winner's `ram_we`/`ram_addr`/`ram_wdata`.
    - `host_gnt=1` if the host won.
    - write → `ARB`; read → `RD`.
  - `RD`:
    - capture `ram_rdata` into `tx_data` (SPI) or `host_rdata` (host).
    - → `ARB`.
- Tie rule (both requesting in `ARB`): set by `SPI_ARB_RR_EN` (see Configuration).
- Pending entry clears on the edge entering `ACC` with SPI as winner. A new RAM command on that same cycle is accepted (set wins over clear), with no overflow.
- `rst` mid-access aborts the access immediately:
  - FSM returns to `ARB`.
  - pending entry and `wr_addr`/`rd_addr` clear to 0.
  - no `tx_valid`/`host_rvalid` is issued for the aborted access.

## Timing
- All outputs are registered. Reset value of every output is 0.
- SPI write: `rx_valid` in cycle N → pending set at N+1 → `ram_en`/`ram_we` high in N+2 (uncontended).
- SPI read: `ram_en` high in N+2 → `ram_rdata` valid in N+3 → `tx_valid` high in N+4 with `tx_data` held until the next read.
- Host: `host_req` seen in `ARB` in cycle M → `host_gnt` and `ram_en` high in M+1. For a read, `host_rvalid` is high in M+3.
- Cycles per access: write 2 (`ARB`, `ACC`); read 3 (`ARB`, `ACC`, `RD`).
- `ram_en`, `host_gnt`, `tx_valid` and `host_rvalid` are never high for more than one cycle per access.

## Configuration
- `SPI_ARB_RR_EN` defined: round-robin on ties.
  - A `last_winner` register (reset = host) makes the loser of the previous tie win the next; SPI wins the first tie after reset.
  - Starvation bound: 2 accesses.
- `SPI_ARB_RR_EN` undefined: fixed priority, SPI always wins ties; the `last_winner` register is removed.

## Structure
- Package `spi_arb_pkg`:
  - FSM state enum (`ARB`, `ACC`, `RD`).
  - opcode constants `OP_WADDR=2'b00`, `OP_WDATA=2'b01`, `OP_RADDR=2'b10`, `OP_RDATA=2'b11`.
  - winner encoding `WIN_SPI`/`WIN_HOST`.
- Sub-module `spi_arb_rr`: 2-way winner select (round-robin or fixed per macro), output `win_spi`.

## Test plan
- Write then read back: frames `0x005`, `0x1A5`, `0x205`, `0x300` → RAM[5]=0xA5; `tx_valid` one cycle with `tx_data=0xA5` at N+4 after the `0x300` pulse.
- Tie: SPI write pending and `host_req` (read addr 5) asserted together, macro defined → SPI `ram_en` first, `host_gnt` 2 cycles later. Repeat the tie → host first. Macro undefined → SPI first both times.
- Overflow: two `01` frames with a host read holding the RAM → second frame dropped, `spi_ovf=1`, RAM holds only the first value.
- Address race: `0x1CC` (pending), then `0x009` before grant → write lands at the original `wr_addr`, not 9.
- Reset in `RD`: `rst` high during the `RD` cycle of an SPI read → no `tx_valid`; all outputs 0; first post-reset tie goes to SPI.
